// File: rtl/sd_read_sequencer.sv
// Session sequencer between the UART command receiver and the SD file reader.
// Handles reader reset/retry, end-of-file idle detection and a FWFT byte FIFO toward UART TX.
module sd_read_sequencer #(
    parameter int RST_CYCLES   = 16,
    parameter int INIT_TIMEOUT = 54000000,
    parameter int IDLE_GAP     = 2700000,
    parameter int MAX_RETRY    = 3,
    parameter int FIFO_AW      = 6
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_data,
    output logic        reader_rstn,
    input  logic        rd_file_found,
    input  logic        rd_outen,
    input  logic [7:0]  rd_outbyte,
    output logic        o_tvalid,
    output logic [7:0]  o_tdata,
    input  logic        o_tready,
    output logic        busy,
    output logic [2:0]  state_code,
    output logic [3:0]  retry_cnt,
    output logic [31:0] byte_cnt,
    output logic        overflow
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_RST = 3'd1, S_WAIT = 3'd2,
        S_STREAM = 3'd3, S_DONE = 3'd4, S_FAIL = 3'd5
    } state_t;

    state_t             state, state_nxt;
    logic [31:0]        timer;
    logic [FIFO_AW:0]   wptr, rptr;
    logic [7:0]         mem [2**FIFO_AW];
    logic               cmd_r, cmd_a, flush, push, pop, do_push, full, empty;
    logic               rst_done, init_to, gap_done;

    assign cmd_r    = cmd_valid && (cmd_data == 8'h72);
    assign cmd_a    = cmd_valid && (cmd_data == 8'h61);
    assign flush    = cmd_r || cmd_a;
    // Flush wins over a same-cycle reader byte: it is neither stored nor counted.
    assign push     = rd_outen && !flush && (state == S_WAIT || state == S_STREAM);
    assign empty    = (wptr == rptr);
    assign full     = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                      (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
    assign pop      = !empty && o_tready;
    assign do_push  = push && (!full || pop);

    assign rst_done = (timer == 32'(RST_CYCLES - 1));
    assign init_to  = (timer == 32'(INIT_TIMEOUT - 1));
    assign gap_done = (byte_cnt != 32'd0) && !rd_outen && (timer == 32'(IDLE_GAP - 1));

    always_ff @(posedge clk) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cmd_r)
            state_nxt = S_RST;
        else if (cmd_a)
            state_nxt = S_IDLE;
        else begin
            case (state)
                S_RST:    if (rst_done) state_nxt = S_WAIT;
                S_WAIT:   if (rd_file_found) state_nxt = S_STREAM;
                          else if (init_to)
                              state_nxt = (retry_cnt < 4'(MAX_RETRY)) ? S_RST : S_FAIL;
                S_STREAM: if (gap_done) state_nxt = S_DONE;
                default:  state_nxt = state;
            endcase
        end
    end

    always_comb begin
        reader_rstn = 1'b0;
        busy        = 1'b0;
        case (state)
            S_RST:            busy = 1'b1;
            S_WAIT, S_STREAM: begin reader_rstn = 1'b1; busy = 1'b1; end
            default: ;
        endcase
    end

    assign state_code = state;
    assign o_tvalid   = !empty;
    assign o_tdata    = mem[rptr[FIFO_AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            timer     <= 32'd0;
            retry_cnt <= 4'd0;
            byte_cnt  <= 32'd0;
            overflow  <= 1'b0;
            wptr      <= '0;
            rptr      <= '0;
        end else begin
            // One timer serves RST length, init timeout and the end-of-file gap.
            if (cmd_r || state_nxt != state)
                timer <= 32'd0;
            else begin
                case (state)
                    S_RST, S_WAIT: timer <= timer + 32'd1;
                    S_STREAM:      if (rd_outen) timer <= 32'd0;
                                   else if (byte_cnt != 32'd0) timer <= timer + 32'd1;
                    default:       timer <= 32'd0;
                endcase
            end

            if (cmd_r) begin
                retry_cnt <= 4'd0;
                byte_cnt  <= 32'd0;
                overflow  <= 1'b0;
            end else begin
                if (state == S_WAIT && state_nxt == S_RST) retry_cnt <= retry_cnt + 4'd1;
                if (push) begin
                    if (byte_cnt != '1) byte_cnt <= byte_cnt + 32'd1;
                    if (full && !pop)   overflow <= 1'b1;
                end
            end

            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (do_push) wptr <= wptr + 1'b1;
                if (pop)     rptr <= rptr + 1'b1;
            end
        end
    end

    // A push into a full FIFO alongside a pop overwrites the slot being read out this cycle.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[FIFO_AW-1:0]] <= rd_outbyte;
    end
endmodule

// File: tb/tb_sd_read_sequencer.sv
// Directed bench for sd_read_sequencer with small timing parameters and a depth-4 FIFO.
module tb_sd_read_sequencer;
    logic        clk = 1'b0;
    logic        rstn, cmd_valid, rd_file_found, rd_outen, o_tready;
    logic [7:0]  cmd_data, rd_outbyte;
    logic        reader_rstn, o_tvalid, busy, overflow;
    logic [7:0]  o_tdata;
    logic [2:0]  state_code;
    logic [3:0]  retry_cnt;
    logic [31:0] byte_cnt;

    int n_chk = 0, n_pass = 0;
    logic [7:0] cap_q[$];

    sd_read_sequencer #(
        .RST_CYCLES(4), .INIT_TIMEOUT(100), .IDLE_GAP(10), .MAX_RETRY(2), .FIFO_AW(2)
    ) dut (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .reader_rstn(reader_rstn), .rd_file_found(rd_file_found), .rd_outen(rd_outen),
        .rd_outbyte(rd_outbyte), .o_tvalid(o_tvalid), .o_tdata(o_tdata), .o_tready(o_tready),
        .busy(busy), .state_code(state_code), .retry_cnt(retry_cnt), .byte_cnt(byte_cnt),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Inputs only change just after posedge, so the negedge view matches the next edge.
    always @(negedge clk) if (o_tvalid && o_tready) cap_q.push_back(o_tdata);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        cmd_valid = 1'b1;
        cmd_data  = b;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rd_outen   = 1'b1;
        rd_outbyte = b;
        tick();
        rd_outen   = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] code, input string tag);
        int n = 0;
        while (state_code != code && n < 500) begin
            tick();
            n++;
        end
        chk(tag, 32'(state_code), 32'(code));
    endtask

    task automatic chk_seq(input string tag, input logic [7:0] base, input int n);
        chk({tag, "_len"}, 32'(cap_q.size()), 32'(n));
        for (int i = 0; i < n; i++)
            chk(tag, (i < cap_q.size()) ? 32'(cap_q[i]) : 32'hdead, 32'(base) + 32'(i));
    endtask

    initial begin
        int cnt, pulses;
        logic [2:0] prev;
        rstn = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00; rd_file_found = 1'b0;
        rd_outen = 1'b0; rd_outbyte = 8'h00; o_tready = 1'b0;
        tick(); tick();
        chk("rst_state", 32'(state_code), 32'd0);
        chk("rst_reader_rstn", 32'(reader_rstn), 32'd0);
        chk("rst_tvalid", 32'(o_tvalid), 32'd0);
        chk("rst_byte_cnt", byte_cnt, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        tick();

        // Normal session: 5 bytes, drained as they arrive, then end-of-file gap.
        o_tready = 1'b1;
        send_cmd(8'h72);
        cnt = 0;
        while (!reader_rstn && cnt < 50) begin cnt++; tick(); end
        chk("rst_pulse_len", 32'(cnt), 32'd4);
        chk("wait_state", 32'(state_code), 32'd2);
        repeat (20) tick();
        rd_file_found = 1'b1;
        tick();
        chk("stream_state", 32'(state_code), 32'd3);
        cap_q.delete();
        push_byte(8'h41);
        chk("lat_tvalid", 32'(o_tvalid), 32'd1);
        chk("lat_tdata", 32'(o_tdata), 32'h41);
        for (int i = 1; i < 5; i++) push_byte(8'h41 + 8'(i));
        cnt = 0;
        while (state_code != 3'd4 && cnt < 100) begin tick(); cnt++; end
        chk("gap_to_done", 32'(cnt), 32'd10);
        chk("done_byte_cnt", byte_cnt, 32'd5);
        chk("done_reader_rstn", 32'(reader_rstn), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        chk_seq("stream_data", 8'h41, 5);

        // Init timeout with retries.
        rd_file_found = 1'b0;
        prev = state_code;
        send_cmd(8'h72);
        cnt = 1; pulses = 0;
        while (state_code != 3'd5 && cnt < 2000) begin
            if (state_code == 3'd1 && prev != 3'd1) pulses++;
            prev = state_code;
            tick();
            cnt++;
        end
        chk("fail_cycles", 32'(cnt), 32'd313);
        chk("fail_pulses", 32'(pulses), 32'd3);
        chk("fail_retry_cnt", 32'(retry_cnt), 32'd2);
        chk("fail_busy", 32'(busy), 32'd0);

        // Overflow: 6 bytes into depth 4 with output stalled.
        rd_file_found = 1'b1;
        o_tready = 1'b0;
        send_cmd(8'h72);
        chk("restart_retry_clr", 32'(retry_cnt), 32'd0);
        wait_state(3'd3, "ovf_stream");
        for (int i = 0; i < 4; i++) push_byte(8'h10 + 8'(i));
        chk("ovf_not_yet", 32'(overflow), 32'd0);
        push_byte(8'h14);
        push_byte(8'h15);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_byte_cnt", byte_cnt, 32'd6);
        chk("ovf_head", 32'(o_tdata), 32'h10);
        cap_q.delete();
        o_tready = 1'b1;
        repeat (6) tick();
        chk_seq("ovf_drain", 8'h10, 4);

        // Full FIFO with simultaneous push and pop: nothing dropped.
        o_tready = 1'b0;
        send_cmd(8'h72);
        chk("r_clears_ovf", 32'(overflow), 32'd0);
        wait_state(3'd3, "full_stream");
        for (int i = 0; i < 4; i++) push_byte(8'h20 + 8'(i));
        cap_q.delete();
        o_tready = 1'b1;
        push_byte(8'h24);
        repeat (6) tick();
        chk("full_pp_ovf", 32'(overflow), 32'd0);
        chk("full_pp_byte_cnt", byte_cnt, 32'd5);
        chk_seq("full_pp_data", 8'h20, 5);

        // Abort mid-stream with bytes queued.
        o_tready = 1'b0;
        send_cmd(8'h72);
        wait_state(3'd3, "abort_stream");
        for (int i = 0; i < 3; i++) push_byte(8'h30 + 8'(i));
        chk("abort_pre_tvalid", 32'(o_tvalid), 32'd1);
        send_cmd(8'h61);
        chk("abort_tvalid", 32'(o_tvalid), 32'd0);
        chk("abort_reader_rstn", 32'(reader_rstn), 32'd0);
        chk("abort_state", 32'(state_code), 32'd0);
        chk("abort_byte_hold", byte_cnt, 32'd3);
        send_cmd(8'h7a);
        chk("other_cmd_ignored", 32'(state_code), 32'd0);
        send_cmd(8'h72);
        chk("abort_r_byte_clr", byte_cnt, 32'd0);
        chk("abort_r_state", 32'(state_code), 32'd1);

        // Synchronous reset mid-stream, with a coincident "r".
        wait_state(3'd3, "sreset_stream");
        for (int i = 0; i < 5; i++) push_byte(8'h50 + 8'(i));
        chk("sreset_pre_ovf", 32'(overflow), 32'd1);
        rstn = 1'b0;
        send_cmd(8'h72);
        rstn = 1'b1;
        chk("sreset_state", 32'(state_code), 32'd0);
        chk("sreset_reader_rstn", 32'(reader_rstn), 32'd0);
        chk("sreset_tvalid", 32'(o_tvalid), 32'd0);
        chk("sreset_byte_cnt", byte_cnt, 32'd0);
        chk("sreset_ovf", 32'(overflow), 32'd0);
        chk("sreset_busy", 32'(busy), 32'd0);
        tick();
        chk("sreset_r_ignored", 32'(state_code), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
